// File: rtl/fifo_playback.sv
// ---------------------------------------------------------------------------
// FifoPlayback (module fifo_playback)
//
// Purpose:
//    Downstream consumer of a 4-bit symbol FIFO. On a start request it drains
//    the FIFO one symbol at a time. Each symbol is shown on an active-low
//    7-segment digit for ON_CYCLES clocks, and then the digit is blanked for
//    GAP_CYCLES clocks. Playback ends when a read request finds the FIFO
//    empty. The block only reads the FIFO; it never writes or deletes.
//
// Ports:
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    start       playback request, only looked at while idle
//    abort       drops any playback in progress back to idle
//    fifo_empty  FIFO empty flag
//    fifo_data   FIFO read data, valid one clock after fifo_re
//    fifo_re     one-cycle read pulse per symbol
//    seg         {g,f,e,d,c,b,a} active-low, 7'h7F is blank
//    busy        high whenever not idle
//    done        one-cycle pulse when playback ends on an empty FIFO
//    sym_cnt     symbols played since the last start, saturates at 63
// ---------------------------------------------------------------------------
module fifo_playback #(
   parameter int ON_CYCLES  = 25_000_000,
   parameter int GAP_CYCLES = 12_500_000,
   parameter int CNT_W      = $clog2(((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       fifo_empty,
   input  logic [3:0] fifo_data,
   output logic       fifo_re,
   output logic [6:0] seg,
   output logic       busy,
   output logic       done,
   output logic [5:0] sym_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      LOAD = 3'd2,
      SHOW = 3'd3,
      GAP  = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [3:0]       symReg_q, symReg_d;
   logic [5:0]       symCnt_q, symCnt_d;

   // Active-low hex glyphs for the digit; letters use the A b C d E F forms.
   function automatic logic [6:0] decodeHex(input logic [3:0] value);
      logic [6:0] code;
      case (value)
         4'h0:    code = 7'h40;
         4'h1:    code = 7'h79;
         4'h2:    code = 7'h24;
         4'h3:    code = 7'h30;
         4'h4:    code = 7'h19;
         4'h5:    code = 7'h12;
         4'h6:    code = 7'h02;
         4'h7:    code = 7'h78;
         4'h8:    code = 7'h00;
         4'h9:    code = 7'h10;
         4'hA:    code = 7'h08;
         4'hB:    code = 7'h03;
         4'hC:    code = 7'h46;
         4'hD:    code = 7'h21;
         4'hE:    code = 7'h06;
         default: code = 7'h0E;
      endcase
      return code;
   endfunction

   // State and datapath registers. Reset is synchronous so everything,
   // including the dwell counter and symbol count, clears on the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         dwell_q  <= '0;
         symReg_q <= '0;
         symCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         dwell_q  <= dwell_d;
         symReg_q <= symReg_d;
         symCnt_q <= symCnt_d;
      end
   end

   // Next-state logic. Abort wins over every transition out of a busy
   // state, and because it skips the LOAD updates the symbol count is held.
   // A read issued in REQ just before an abort is simply never loaded.
   always_comb begin
      state_d  = state_q;
      dwell_d  = dwell_q;
      symReg_d = symReg_q;
      symCnt_d = symCnt_q;
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d  = REQ;
                  symCnt_d = '0;
               end
            end
            REQ: begin
               if (fifo_empty) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
               end
            end
            LOAD: begin
               symReg_d = fifo_data;
               dwell_d  = '0;
               if (symCnt_q != 6'd63) begin
                  symCnt_d = symCnt_q + 6'd1;
               end
               state_d  = SHOW;
            end
            SHOW: begin
               if (dwell_q == ON_LAST) begin
                  dwell_d = '0;
                  state_d = GAP;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            GAP: begin
               if (dwell_q == GAP_LAST) begin
                  dwell_d = '0;
                  state_d = REQ;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from the current state. The read pulse is gated by
   // fifo_empty so a read is never requested from an empty FIFO.
   always_comb begin
      fifo_re = (state_q == REQ) && !fifo_empty;
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      seg     = 7'h7F;
      if (state_q == SHOW) begin
         seg = decodeHex(symReg_q);
      end
      sym_cnt = symCnt_q;
   end

endmodule

// File: tb/tb_fifo_playback.sv
// ---------------------------------------------------------------------------
// tb_fifo_playback
//
// Purpose:
//    Directed bench for fifo_playback with ON_CYCLES=4 and GAP_CYCLES=2.
//    A small behavioural FIFO (array plus read/write pointers, registered
//    read data) feeds the design. Outputs are sampled on the falling edge.
//    Cycle naming: start is sampled at edge N; the first falling edge after
//    that is cycle N+1 (REQ). Each symbol then takes 4+2+2 = 8 clocks, so
//    with k symbols REQ sees empty at N+1+8k and done is seen at N+2+8k.
// ---------------------------------------------------------------------------
module tb_fifo_playback;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       fifoEmpty;
   logic [3:0] fifoData;
   logic       fifoRe;
   logic [6:0] seg;
   logic       busy;
   logic       done;
   logic [5:0] symCnt;

   logic [3:0] fifoMem [0:63];
   int         wrPtr;
   int         rdPtr;
   int         reCount;
   logic       reOnEmpty;

   int         total;
   int         bad;

   logic [6:0] segTable [0:15];

   fifo_playback #(
      .ON_CYCLES  (4),
      .GAP_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .fifo_empty (fifoEmpty),
      .fifo_data  (fifoData),
      .fifo_re    (fifoRe),
      .seg        (seg),
      .busy       (busy),
      .done       (done),
      .sym_cnt    (symCnt)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model: empty when the pointers meet, read data registered one
   // clock after the read pulse. Also tracks read pulses and any read
   // attempted while empty.
   assign fifoEmpty = (wrPtr == rdPtr);

   initial begin
      rdPtr     = 0;
      fifoData  = 4'h0;
      reCount   = 0;
      reOnEmpty = 1'b0;
   end

   always @(posedge clk) begin
      if (fifoRe) begin
         fifoData <= fifoMem[rdPtr];
         rdPtr    <= rdPtr + 1;
         reCount  <= reCount + 1;
         if (fifoEmpty) begin
            reOnEmpty <= 1'b1;
         end
      end
   end

   // One clock: step past the rising edge and sample on the falling edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic pushSym(input logic [3:0] value);
      fifoMem[wrPtr] = value;
      wrPtr = wrPtr + 1;
   endtask

   // Pulse start for one clock; returns at cycle N+1.
   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      total = 0;
      bad   = 0;
      wrPtr = 0;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      tick(2);

      // Reset values.
      checkOutput("rst_seg",    8'(seg),    8'h7F);
      checkOutput("rst_busy",   8'(busy),   8'h00);
      checkOutput("rst_done",   8'(done),   8'h00);
      checkOutput("rst_re",     8'(fifoRe), 8'h00);
      checkOutput("rst_symcnt", 8'(symCnt), 8'h00);
      rst = 1'b0;
      tick();

      // Empty FIFO: REQ at N+1, done at N+2, no read.
      $display("[TB] empty FIFO run");
      applyStimulus();
      checkOutput("empty_busy_n1", 8'(busy),   8'h01);
      checkOutput("empty_re_n1",   8'(fifoRe), 8'h00);
      checkOutput("empty_done_n1", 8'(done),   8'h00);
      tick();
      checkOutput("empty_done_n2", 8'(done),   8'h01);
      checkOutput("empty_cnt_n2",  8'(symCnt), 8'h00);
      tick();
      checkOutput("empty_done_n3", 8'(done),   8'h00);
      checkOutput("empty_busy_n3", 8'(busy),   8'h00);
      checkOutput("empty_reads",   8'(reCount), 8'd0);

      // Two symbols 3, A.
      $display("[TB] two-symbol run");
      pushSym(4'h3);
      pushSym(4'hA);
      applyStimulus();
      checkOutput("two_re_n1", 8'(fifoRe), 8'h01);
      tick();
      checkOutput("two_re_n2",  8'(fifoRe), 8'h00);
      checkOutput("two_seg_n2", 8'(seg),    8'h7F);
      for (int k = 3; k <= 6; k++) begin
         tick();
         checkOutput($sformatf("two_seg3_n%0d", k), 8'(seg), 8'h30);
      end
      checkOutput("two_cnt_n6", 8'(symCnt), 8'd1);
      for (int k = 7; k <= 8; k++) begin
         tick();
         checkOutput($sformatf("two_gap_n%0d", k), 8'(seg), 8'h7F);
      end
      tick();
      checkOutput("two_re_n9", 8'(fifoRe), 8'h01);
      tick();
      for (int k = 11; k <= 14; k++) begin
         tick();
         checkOutput($sformatf("two_segA_n%0d", k), 8'(seg), 8'h08);
      end
      tick(3);
      checkOutput("two_re_n17",   8'(fifoRe), 8'h00);
      checkOutput("two_done_n17", 8'(done),   8'h00);
      tick();
      checkOutput("two_done_n18", 8'(done),   8'h01);
      checkOutput("two_cnt_n18",  8'(symCnt), 8'd2);
      checkOutput("two_reads",    8'(reCount), 8'd2);
      tick();
      checkOutput("two_busy_n19", 8'(busy), 8'h00);

      // Sixteen symbols 1..F,0 against the glyph table.
      $display("[TB] sixteen-symbol run");
      for (int i = 1; i <= 16; i++) begin
         pushSym(4'(i));
      end
      applyStimulus();
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("all_re_%0d", i), 8'(fifoRe), 8'h01);
         tick();
         for (int s = 0; s < 4; s++) begin
            tick();
            checkOutput($sformatf("all_seg_%0d_%0d", i, s), 8'(seg), 8'(segTable[(i + 1) % 16]));
         end
         for (int g = 0; g < 2; g++) begin
            tick();
            checkOutput($sformatf("all_gap_%0d_%0d", i, g), 8'(seg), 8'h7F);
         end
         tick();
      end
      checkOutput("all_re_end", 8'(fifoRe), 8'h00);
      tick();
      checkOutput("all_done", 8'(done),   8'h01);
      checkOutput("all_cnt",  8'(symCnt), 8'd16);
      tick();

      // Abort during the second SHOW of a three-symbol run.
      $display("[TB] abort run");
      pushSym(4'h5);
      pushSym(4'h6);
      pushSym(4'h7);
      applyStimulus();
      tick(11);
      checkOutput("abort_seg_n12", 8'(seg), 8'h02);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", 8'(busy),   8'h00);
      checkOutput("abort_seg",  8'(seg),    8'h7F);
      checkOutput("abort_done", 8'(done),   8'h00);
      checkOutput("abort_cnt",  8'(symCnt), 8'd2);
      tick();
      checkOutput("abort_done_later", 8'(done), 8'h00);
      checkOutput("abort_busy_later", 8'(busy), 8'h00);

      // Reset in the GAP of symbol 7, then play the remaining 8, 9.
      $display("[TB] reset mid-gap run");
      pushSym(4'h8);
      pushSym(4'h9);
      applyStimulus();
      tick(2);
      checkOutput("rstg_seg_n3", 8'(seg), 8'h78);
      tick(4);
      checkOutput("rstg_gap_n7",  8'(seg),  8'h7F);
      checkOutput("rstg_busy_n7", 8'(busy), 8'h01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstg_re",   8'(fifoRe), 8'h00);
      checkOutput("rstg_seg",  8'(seg),    8'h7F);
      checkOutput("rstg_busy", 8'(busy),   8'h00);
      checkOutput("rstg_done", 8'(done),   8'h00);
      checkOutput("rstg_cnt",  8'(symCnt), 8'h00);
      tick();
      applyStimulus();
      tick(2);
      checkOutput("rstg_seg8_n3", 8'(seg), 8'h00);
      tick(8);
      checkOutput("rstg_seg9_n11", 8'(seg), 8'h10);
      tick(7);
      checkOutput("rstg_done_n18", 8'(done),   8'h01);
      checkOutput("rstg_cnt_n18",  8'(symCnt), 8'd2);
      tick();

      // Symbol pushed during the GAP of what was the final symbol.
      $display("[TB] late push run");
      pushSym(4'h2);
      applyStimulus();
      tick(2);
      checkOutput("late_seg2_n3", 8'(seg), 8'h24);
      tick(4);
      pushSym(4'h4);
      tick(2);
      checkOutput("late_re_n9", 8'(fifoRe), 8'h01);
      tick(2);
      checkOutput("late_seg4_n11", 8'(seg), 8'h19);
      tick(6);
      checkOutput("late_re_n17",   8'(fifoRe), 8'h00);
      checkOutput("late_done_n17", 8'(done),   8'h00);
      tick();
      checkOutput("late_done_n18", 8'(done),   8'h01);
      checkOutput("late_cnt_n18",  8'(symCnt), 8'd2);
      tick();
      checkOutput("late_busy_n19", 8'(busy), 8'h00);

      // Every pushed symbol was read exactly once, never from an empty FIFO.
      checkOutput("final_reads",     8'(reCount),   8'd25);
      checkOutput("final_rdptr",     8'(rdPtr),     8'(wrPtr));
      checkOutput("final_re_empty",  8'(reOnEmpty), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
